// File: rtl/muxn_rr.sv
// muxn_rr -- N-channel to one registered multiplexer with valid/ready handshakes.
//
// Each cycle the arbiter grants at most one channel that presents din_valid.
// The granted word is captured into the output register whenever that register
// is empty or is being drained in the same cycle.
//
// Configuration macro: MUXN_RR_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting after the last granted channel
//   undefined -> fixed priority, lowest valid channel index wins
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   din         packed channel data, channel i at [i*WIDTH +: WIDTH]
//   din_valid   per-channel data valid
//   din_ready   per-channel accept strobe (combinational, one-hot or zero)
//   dout        registered selected data
//   dout_sel    registered index of the channel that sourced dout
//   dout_valid  output register holds a valid word
//   dout_ready  downstream accepts dout this cycle
module muxn_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_valid,
    output logic [CHANNELS-1:0]       din_ready,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_sel,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    logic             load;
    logic             any_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;

`ifdef MUXN_RR_ROUND_ROBIN_EN
    logic [SEL_W-1:0] last;
`endif

    assign load      = !dout_valid || dout_ready;
    assign any_valid = |din_valid;

    always_comb begin : grant_select
        grant = '0;
`ifdef MUXN_RR_ROUND_ROBIN_EN
        // Walk offsets from farthest to nearest so the channel closest after
        // 'last' is written last and wins; 'last' itself sits at offset
        // CHANNELS. Explicit wrap keeps non-power-of-2 counts in range.
        for (int unsigned k = CHANNELS; k > 0; k--) begin
            int unsigned      idx;
            logic [SEL_W-1:0] idx_s;
            idx = int'(last) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            idx_s = SEL_W'(idx);
            if (din_valid[idx_s]) begin
                grant = idx_s;
            end
        end
`else
        // Descending scan: the lowest valid index is written last and wins.
        for (int unsigned c = CHANNELS; c > 0; c--) begin
            if (din_valid[c-1]) begin
                grant = SEL_W'(c - 1);
            end
        end
`endif
    end

    // Only the granted slice reaches the register, so X on idle channels
    // cannot leak into dout.
    always_comb begin : data_select
        grant_data = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (SEL_W'(c) == grant) begin
                grant_data = din[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : ready_gen
        din_ready = '0;
        if (!rst && load && any_valid) begin
            din_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_sel   <= '0;
`ifdef MUXN_RR_ROUND_ROBIN_EN
            last       <= SEL_W'(CHANNELS - 1);
`endif
        end else if (load) begin
            if (any_valid) begin
                dout       <= grant_data;
                dout_sel   <= grant;
                dout_valid <= 1'b1;
`ifdef MUXN_RR_ROUND_ROBIN_EN
                last       <= grant;
`endif
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr -- self-checking bench for muxn_rr.
// Two instances share stimulus: a 4-channel one and a 3-channel one (driven by
// the low three channels) to exercise wrap-around on a non-power-of-2 count.
// Reference model: arbitration is computed as "first valid channel at distance
// 1..N after a base index, modulo N"; fixed priority is that rule with the
// base permanently at N-1.
module tb_muxn_rr;

    localparam int W  = 8;
    localparam int NA = 4;
    localparam int NB = 3;
`ifdef MUXN_RR_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NA*W-1:0] din;
    logic [NA-1:0]   din_valid;
    logic            dout_ready;

    logic [NA-1:0]   rdy_a;
    logic [W-1:0]    dout_a;
    logic [1:0]      sel_a;
    logic            val_a;
    logic [NB-1:0]   rdy_b;
    logic [W-1:0]    dout_b;
    logic [1:0]      sel_b;
    logic            val_b;

    muxn_rr #(.WIDTH(W), .CHANNELS(NA)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_a),
        .dout       (dout_a),
        .dout_sel   (sel_a),
        .dout_valid (val_a),
        .dout_ready (dout_ready)
    );

    muxn_rr #(.WIDTH(W), .CHANNELS(NB)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din        (din[NB*W-1:0]),
        .din_valid  (din_valid[NB-1:0]),
        .din_ready  (rdy_b),
        .dout       (dout_b),
        .dout_sel   (sel_b),
        .dout_valid (val_b),
        .dout_ready (dout_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance: 0 -> dut_a, 1 -> dut_b.
    int m_n[2]     = '{NA, NB};
    int m_valid[2] = '{0, 0};
    int m_dout[2]  = '{0, 0};
    int m_sel[2]   = '{0, 0};
    int m_last[2]  = '{NA - 1, NB - 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NA-1:0] v, input int n, input int last);
        int base;
        base = RR ? last : n - 1;
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (base + k) % n;
            if (v[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    // One clock: inputs are already applied (after a falling edge).
    task automatic cycle();
        int            g[2];
        int            er[2];
        logic [NA-1:0] v;
        #1;
        for (int i = 0; i < 2; i++) begin
            v     = (i == 0) ? din_valid : {1'b0, din_valid[NB-1:0]};
            g[i]  = pick(v, m_n[i], m_last[i]);
            er[i] = (!rst && (m_valid[i] == 0 || dout_ready) && g[i] >= 0) ? (1 << g[i]) : 0;
        end
        chk("din_ready_a", {28'd0, rdy_a}, er[0]);
        chk("din_ready_b", {29'd0, rdy_b}, er[1]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid[i] = 0;
                m_dout[i]  = 0;
                m_sel[i]   = 0;
                m_last[i]  = m_n[i] - 1;
            end else if (m_valid[i] == 0 || dout_ready) begin
                if (g[i] >= 0) begin
                    m_dout[i]  = int'(din[g[i]*W +: W]);
                    m_sel[i]   = g[i];
                    m_valid[i] = 1;
                    m_last[i]  = g[i];
                end else begin
                    m_valid[i] = 0;
                end
            end
        end
        #1;
        chk("dout_valid_a", {31'd0, val_a}, m_valid[0]);
        chk("dout_a",       {24'd0, dout_a}, m_dout[0]);
        chk("dout_sel_a",   {30'd0, sel_a}, m_sel[0]);
        chk("dout_valid_b", {31'd0, val_b}, m_valid[1]);
        chk("dout_b",       {24'd0, dout_b}, m_dout[1]);
        chk("dout_sel_b",   {30'd0, sel_b}, m_sel[1]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int wrap_seq[3] = '{0, 2, 0};

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = '0;
        dout_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with every channel requesting.
        din_valid = 4'b1111;
        din       = 32'h44332211;
        cycle();
        cycle();
        rst       = 1'b0;
        din_valid = 4'b0000;
        cycle();
        chk("reset_release_valid", {31'd0, val_a}, 0);

        // Single channel 2 with A5.
        din        = 32'h11A52233;
        din_valid  = 4'b0100;
        dout_ready = 1'b1;
        cycle();
        chk("single_dout", {24'd0, dout_a}, 32'hA5);
        chk("single_sel",  {30'd0, sel_a}, 2);
        din_valid = 4'b0000;
        cycle();
        chk("single_drain", {31'd0, val_a}, 0);

        // All channels valid from a fresh reset.
        do_reset();
        din_valid  = 4'b1111;
        dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = {8'hD0 + 8'(k), 8'hC0 + 8'(k), 8'hB0 + 8'(k), 8'hA0 + 8'(k)};
            cycle();
            chk("rr_seq", {30'd0, sel_a}, RR ? (k % NA) : 0);
        end

        // Backpressure with 3C parked in the output register.
        do_reset();
        din        = 32'h0000003C;
        din_valid  = 4'b0001;
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
        din_valid  = 4'b0011;
        din        = 32'h00007E3C;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold", {24'd0, dout_a}, 32'h3C);
        end
        dout_ready = 1'b1;
        cycle();
        chk("bp_next_grant", {30'd0, sel_a}, RR ? 1 : 0);

        // Wrap on the 3-channel instance: last starts at 2 after reset.
        do_reset();
        din_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            din = {8'h00, 8'h30 + 8'(k), 8'h00, 8'h10 + 8'(k)};
            cycle();
            chk("wrap_seq_b", {30'd0, sel_b}, RR ? wrap_seq[k] : 0);
        end

        // Reset while the output is stalled.
        din_valid  = 4'b0010;
        dout_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("midreset_valid", {31'd0, val_a}, 0);
        rst        = 1'b0;
        din_valid  = 4'b1111;
        dout_ready = 1'b1;
        cycle();
        chk("midreset_first", {30'd0, sel_a}, 0);

        // Randomized traffic; idle channels carry X to confirm they are ignored.
        for (int k = 0; k < 400; k++) begin
            rst        = ($urandom_range(0, 39) == 0);
            din_valid  = 4'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
            din        = $urandom;
            for (int c = 0; c < NA; c++) begin
                if (!din_valid[c] && $urandom_range(0, 1) == 1) begin
                    din[c*W +: W] = 'x;
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of input channels, legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = $clog2(CHANNELS), meaning channel index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port din_valid  input  CHANNELS  per-channel data-valid.
REQ-008 SHALL have port din_ready  output  CHANNELS  per-channel accept strobe, combinational.
REQ-009 SHALL have port dout  output  WIDTH  registered selected data.
REQ-010 SHALL have port dout_sel  output  SEL_W  registered index of the channel that sourced dout.
REQ-011 SHALL have port dout_valid  output  1  output register holds a valid word.
REQ-012 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.

Function
REQ-013 SHALL define load = !dout_valid || dout_ready; an output transfer occurs when dout_valid && dout_ready.
REQ-014 SHALL grant at most one channel per cycle, chosen among channels with din_valid=1.
REQ-015 SHALL assert din_ready[g] only for granted channel g and only when load=1; all other din_ready bits 0.
REQ-016 SHALL, on input transfer (din_valid[g] && din_ready[g]), register din[g] into dout, g into dout_sel, and set dout_valid=1 next cycle (latency 1 clk).
REQ-017 SHALL, when load=1 and no din_valid bit set, clear dout_valid next cycle; dout and dout_sel retain previous values.
REQ-018 SHALL hold dout, dout_sel, dout_valid stable while dout_valid=1 and dout_ready=0 (backpressure).
REQ-019 SHALL sustain one transfer per cycle when dout_ready=1 and any din_valid=1 continuously.
REQ-020 SHALL keep an internal last-grant pointer last[SEL_W-1:0], updated to g only on an input transfer.
REQ-021 SHALL not expect din_valid to depend on din_ready (no combinational loop through the block).
REQ-022 SHALL ignore din contents of non-granted channels; X on them SHALL NOT propagate to dout.

Reset
REQ-023 SHALL, on clk edge with rst=1, set dout_valid=0, dout=0, dout_sel=0, last=CHANNELS-1 (channel 0 highest priority after reset).
REQ-024 SHALL drive din_ready=0 during any cycle rst=1; data in flight at reset is discarded.
REQ-025 SHALL give rst priority over all simultaneous handshake events.

Configuration
REQ-026 SHALL honour macro MUXN_RR_ROUND_ROBIN_EN.
REQ-027 With MUXN_RR_ROUND_ROBIN_EN defined: grant = first valid channel scanning last+1, last+2, ... wrapping from CHANNELS-1 to 0 (also for non-power-of-2 CHANNELS); last itself searched last.
REQ-028 Without MUXN_RR_ROUND_ROBIN_EN: fixed priority, grant = lowest-index valid channel; last register SHALL be absent; other behaviour identical.

Verification
REQ-029 Reset: rst=1 two cycles with din_valid=4'b1111 -> din_ready=0, dout_valid=0, dout=0, dout_sel=0 throughout and one cycle after release.
REQ-030 Single channel: din_valid=4'b0100, din[2]=8'hA5, dout_ready=1 -> next cycle dout=8'hA5, dout_sel=2, dout_valid=1; following cycle dout_valid=0 once din_valid=0.
REQ-031 Round-robin (macro on): din_valid=4'b1111 held, dout_ready=1 -> dout_sel sequence 0,1,2,3,0 on consecutive cycles; macro off -> 0,0,0,0,0.
REQ-032 Backpressure: dout_valid=1, dout=8'h3C, dout_ready=0 for 5 cycles with din_valid=4'b0011 -> dout stays 8'h3C, din_ready=0; on dout_ready=1 next grant follows last pointer.
REQ-033 Wrap with CHANNELS=3 (macro on): last=2, din_valid=3'b101 -> grant channel 0 next, then 2, then 0.
REQ-034 Reset mid-stream: rst=1 while dout_valid=1 and dout_ready=0 -> dout_valid=0 next cycle; first post-reset grant with all valid is channel 0.
